axi_rd2ram_mburst: RTL and testbench
====================================

Name: axi_rd2ram_mburst

Overview:
Parametrised successor to the single-burst DDR-to-ibuf read path. It reads I_len beats from DDR over an AXI4 master read channel and writes them into the ibuf sdpram write port, starting at a programmable RAM offset.
- Splits the transfer into bursts of at most C_MAX_BURST beats.
- Never lets a burst cross a 4 KB boundary.
- Keeps up to C_MAX_OUTSTANDING read bursts in flight.
- Reports a sticky response error.
It replaces the read half of the cnna load/store sequencer and uses the same ap_start/done/idle/ready handshake.

Parameters:
- C_M_AXI_ID_WIDTH, 1, AXI ID width.
- C_M_AXI_ADDR_WIDTH, 32, AXI byte-address width.
- C_M_AXI_DATA_WIDTH, 128, AXI data width and RAM data width. Must be a power of 2 and at least 32.
- C_M_AXI_LEN_WIDTH, 8, arlen width (AXI4).
- C_RAM_ADDR_WIDTH, 10, RAM word-address width.
- C_LEN_WIDTH, 16, transfer length width, in beats.
- C_MAX_BURST, 16, maximum beats per burst. Range 1..256.
- C_MAX_OUTSTANDING, 4, maximum AR bursts without a completed rlast. Range 1..16.

Ports:
- I_clk  in  1  clock
- I_rst  in  1  synchronous active-high reset
- I_ap_start  in  1  level start
- O_ap_done  out  1  one-cycle completion pulse
- O_ap_idle  out  1  engine idle
- O_ap_ready  out  1  one-cycle pulse, same cycle as O_ap_done
- I_base_addr  in  C_M_AXI_ADDR_WIDTH  DDR byte start address; beat-aligned, low log2(bytes/beat) bits forced to 0
- I_len  in  C_LEN_WIDTH  beats to transfer
- I_ram_base  in  C_RAM_ADDR_WIDTH  first RAM word address
- O_err  out  1  sticky: any rresp != OKAY during the current job
- O_waddr  out  C_RAM_ADDR_WIDTH  RAM write address
- O_wdata  out  C_M_AXI_DATA_WIDTH  RAM write data
- O_wr  out  1  RAM write enable
- O_maxi_arid  out  C_M_AXI_ID_WIDTH  constant 0
- O_maxi_araddr  out  C_M_AXI_ADDR_WIDTH  burst address
- O_maxi_arlen  out  C_M_AXI_LEN_WIDTH  beats-1
- O_maxi_arsize  out  3  constant log2(C_M_AXI_DATA_WIDTH/8)
- O_maxi_arburst  out  2  constant 2'b01 (INCR)
- O_maxi_arcache  out  4  constant 4'b0011
- O_maxi_arprot  out  3  constant 0
- O_maxi_arvalid  out  1  address valid
- I_maxi_arready  in  1  address ready
- I_maxi_rdata  in  C_M_AXI_DATA_WIDTH  read data
- I_maxi_rresp  in  2  read response
- I_maxi_rlast  in  1  last beat of burst
- I_maxi_rvalid  in  1  read valid
- O_maxi_rready  out  1  read ready

Behaviour:
- Reset values: O_ap_idle=1; O_ap_done, O_ap_ready, O_err, O_wr, O_maxi_arvalid, O_maxi_rready = 0; O_waddr, O_maxi_araddr, O_maxi_arlen = 0.
- Start: a job is accepted on a rising edge of I_ap_start (registered previous value) while in IDLE.
  - I_base_addr, I_len and I_ram_base are latched that cycle.
  - O_ap_idle falls the next cycle and O_err clears.
  - A rising edge while busy is ignored.
- FSM: IDLE -> CALC -> ADDR -> (CALC | DRAIN) -> DONE -> IDLE.
  - CALC (1 cycle): beats = min(remaining, C_MAX_BURST, (4096 - addr[11:0]) / bytes_per_beat); arlen = beats-1.
  - ADDR: hold arvalid with araddr and arlen stable until arready. Enter ADDR only if outstanding < C_MAX_OUTSTANDING; otherwise stall in CALC.
  - After the handshake: addr += beats*bytes_per_beat, remaining -= beats. Go to CALC if remaining > 0, else DRAIN.
  - DRAIN: wait for outstanding == 0 and the final RAM write to be issued.
  - DONE: O_ap_done and O_ap_ready pulse for one cycle, O_ap_idle = 1 the next cycle, then IDLE.
- Outstanding counter: +1 on the AR handshake, -1 on rvalid&rready&rlast. Both in the same cycle leaves it unchanged.
- O_maxi_rready = 1 whenever not IDLE (the RAM always accepts).
- RAM writes: exactly 1 cycle after each R handshake, with registered O_wr=1, O_wdata=rdata and O_waddr=ram_ptr. ram_ptr starts at I_ram_base, increments per beat, and wraps modulo 2^C_RAM_ADDR_WIDTH.
- Errors: any rresp != 2'b00 on a handshake sets O_err. The data is still written and the job still completes.
- I_len == 0: no AR is issued; CALC goes straight to DRAIN/DONE and O_ap_done pulses within 4 cycles of start.
- I_rst mid-job: all state and outputs return to reset values immediately. Dropping arvalid without a handshake is permitted only under system reset.
- R beats are expected only while busy; if rvalid arrives in IDLE, rready stays 0.

Decomposition:
- Package cnna_axi_pkg holds:
  - FSM state enum
  - AXI_BURST_INCR and AXI_RESP_OKAY
  - C_4KB = 4096
  - clog2 function
  - bytes_per_beat / arsize derivation
- Sub-module axi_burst_calc: combinational min(remaining, max, to-4KB) computation producing beats and arlen. It is reused by the future write-side successor.

Test Plan:
- DATA=128, MAX_BURST=16, base 0x1000, len 40, ram_base 0 -> AR (0x1000, len 15), (0x1100, 15), (0x1200, 7); RAM writes addr 0..39 in order; one done pulse; O_err=0.
- base 0x1F80, len 20 -> AR (0x1F80, len 7), (0x2000, len 11); no burst crosses 0x2000; 20 writes.
- len 128, slave withholds rvalid for 200 cycles -> exactly 4 ARs issued, then arvalid stays low until the first rlast; all 128 beats written; done pulses.
- len 0 -> no arvalid; O_ap_done pulses once; O_ap_idle returns to 1; no O_wr.
- len 16, rresp=2'b10 on beat 5 -> O_err=1 from beat 5 on; 16 writes; done pulses; the next start clears O_err.
- ram_base 1020, len 8, then reset asserted mid-second job -> writes to 1020..1023, 0..3; after reset all outputs are at reset values and a new start completes normally.

Source files
------------

// File: rtl/cnna_axi_pkg.sv
// Shared AXI read-path definitions: FSM states, AXI encodings and width helpers
// used by the burst calculator and the DDR-to-RAM read engine.
package cnna_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_ADDR,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         C_4KB          = 4096;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int bytes_per_beat(input int data_width);
        return data_width / 8;
    endfunction

    function automatic logic [2:0] arsize_of(input int data_width);
        return 3'(clog2(bytes_per_beat(data_width)));
    endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// Combinational burst sizing: beats = min(remaining, max burst, beats left before the
// next 4 KB boundary). Shared between the read engine and the future write engine.
module axi_burst_calc
    import cnna_axi_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 128,
    parameter int C_MAX_BURST   = 16,
    parameter int C_LEN_WIDTH   = 16,
    parameter int C_AXLEN_WIDTH = 8
) (
    input  logic [11:0]              I_addr_lo,
    input  logic [C_LEN_WIDTH-1:0]   I_remaining,
    output logic [C_LEN_WIDTH-1:0]   O_beats,
    output logic [C_AXLEN_WIDTH-1:0] O_arlen
);

    localparam int BPB_LOG2 = clog2(bytes_per_beat(C_DATA_WIDTH));

    logic [12:0] to_4kb;
    logic [31:0] cap;
    logic [31:0] beats;

    always_comb begin
        // 13 bits so that an aligned address yields a full 4096-byte window
        to_4kb = (13'(C_4KB) - {1'b0, I_addr_lo}) >> BPB_LOG2;
        cap    = 32'(C_MAX_BURST);
        if ({19'd0, to_4kb} < cap) begin
            cap = {19'd0, to_4kb};
        end
        beats = (32'(I_remaining) < cap) ? 32'(I_remaining) : cap;
    end

    assign O_beats = C_LEN_WIDTH'(beats);
    assign O_arlen = C_AXLEN_WIDTH'(beats - 32'd1);

endmodule

// File: rtl/axi_rd2ram_mburst.sv
// Multi-burst AXI4 read engine: streams I_len beats from DDR into the ibuf RAM
// write port, splitting at C_MAX_BURST / 4 KB and keeping several bursts in flight.
module axi_rd2ram_mburst
    import cnna_axi_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int C_M_AXI_LEN_WIDTH  = 8,
    parameter int C_RAM_ADDR_WIDTH   = 10,
    parameter int C_LEN_WIDTH        = 16,
    parameter int C_MAX_BURST        = 16,
    parameter int C_MAX_OUTSTANDING  = 4
) (
    input  logic                          I_clk,
    input  logic                          I_rst,
    input  logic                          I_ap_start,
    output logic                          O_ap_done,
    output logic                          O_ap_idle,
    output logic                          O_ap_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_base_addr,
    input  logic [C_LEN_WIDTH-1:0]        I_len,
    input  logic [C_RAM_ADDR_WIDTH-1:0]   I_ram_base,
    output logic                          O_err,
    output logic [C_RAM_ADDR_WIDTH-1:0]   O_waddr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] O_wdata,
    output logic                          O_wr,
    output logic [C_M_AXI_ID_WIDTH-1:0]   O_maxi_arid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] O_maxi_araddr,
    output logic [C_M_AXI_LEN_WIDTH-1:0]  O_maxi_arlen,
    output logic [2:0]                    O_maxi_arsize,
    output logic [1:0]                    O_maxi_arburst,
    output logic [3:0]                    O_maxi_arcache,
    output logic [2:0]                    O_maxi_arprot,
    output logic                          O_maxi_arvalid,
    input  logic                          I_maxi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] I_maxi_rdata,
    input  logic [1:0]                    I_maxi_rresp,
    input  logic                          I_maxi_rlast,
    input  logic                          I_maxi_rvalid,
    output logic                          O_maxi_rready
);

    localparam int BPB_LOG2 = clog2(bytes_per_beat(C_M_AXI_DATA_WIDTH));
    localparam int OUT_W    = clog2(C_MAX_OUTSTANDING + 1);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
        {{(C_M_AXI_ADDR_WIDTH - BPB_LOG2){1'b1}}, {BPB_LOG2{1'b0}}};

    state_e                          state_q, state_d;
    logic                            start_prev_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_LEN_WIDTH-1:0]          remaining_q, remaining_d;
    logic [C_LEN_WIDTH-1:0]          beats_q, beats_d;
    logic [C_M_AXI_LEN_WIDTH-1:0]    arlen_q, arlen_d;
    logic [OUT_W-1:0]                outstanding_q;
    logic [C_RAM_ADDR_WIDTH-1:0]     ram_ptr_q;
    logic [C_RAM_ADDR_WIDTH-1:0]     waddr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic                            wr_q;
    logic                            err_q;

    logic [C_LEN_WIDTH-1:0]          calc_beats;
    logic [C_M_AXI_LEN_WIDTH-1:0]    calc_arlen;
    logic                            accept;
    logic                            ar_hs;
    logic                            r_hs;
    logic                            r_last_hs;

    axi_burst_calc #(
        .C_DATA_WIDTH  (C_M_AXI_DATA_WIDTH),
        .C_MAX_BURST   (C_MAX_BURST),
        .C_LEN_WIDTH   (C_LEN_WIDTH),
        .C_AXLEN_WIDTH (C_M_AXI_LEN_WIDTH)
    ) u_burst_calc (
        .I_addr_lo   (addr_q[11:0]),
        .I_remaining (remaining_q),
        .O_beats     (calc_beats),
        .O_arlen     (calc_arlen)
    );

    assign accept    = (state_q == ST_IDLE) && I_ap_start && !start_prev_q;
    assign ar_hs     = O_maxi_arvalid && I_maxi_arready;
    assign r_hs      = I_maxi_rvalid && O_maxi_rready;
    assign r_last_hs = r_hs && I_maxi_rlast;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        arlen_d     = arlen_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_CALC;
                    addr_d      = I_base_addr & ALIGN_MASK;
                    remaining_d = I_len;
                end
            end
            ST_CALC: begin
                if (remaining_q == '0) begin
                    state_d = ST_DRAIN;
                end else if (outstanding_q < OUT_W'(C_MAX_OUTSTANDING)) begin
                    state_d = ST_ADDR;
                    beats_d = calc_beats;
                    arlen_d = calc_arlen;
                end
            end
            ST_ADDR: begin
                if (I_maxi_arready) begin
                    addr_d      = addr_q + (C_M_AXI_ADDR_WIDTH'(beats_q) << BPB_LOG2);
                    remaining_d = remaining_q - beats_q;
                    state_d     = (remaining_q == beats_q) ? ST_DRAIN : ST_CALC;
                end
            end
            ST_DRAIN: begin
                // the last beat's RAM write is registered in the same cycle the count hits 0
                if (outstanding_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q       <= ST_IDLE;
            start_prev_q  <= 1'b0;
            addr_q        <= '0;
            remaining_q   <= '0;
            beats_q       <= '0;
            arlen_q       <= '0;
            outstanding_q <= '0;
            ram_ptr_q     <= '0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            wr_q          <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= I_ap_start;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            beats_q      <= beats_d;
            arlen_q      <= arlen_d;
            if (ar_hs && !r_last_hs) begin
                outstanding_q <= outstanding_q + OUT_W'(1);
            end else if (r_last_hs && !ar_hs) begin
                outstanding_q <= outstanding_q - OUT_W'(1);
            end
            wr_q <= r_hs;
            if (r_hs) begin
                wdata_q   <= I_maxi_rdata;
                waddr_q   <= ram_ptr_q;
                ram_ptr_q <= ram_ptr_q + C_RAM_ADDR_WIDTH'(1);
            end else if (accept) begin
                ram_ptr_q <= I_ram_base;
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (r_hs && (I_maxi_rresp != AXI_RESP_OKAY)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign O_ap_done      = (state_q == ST_DONE);
    assign O_ap_ready     = (state_q == ST_DONE);
    assign O_ap_idle      = (state_q == ST_IDLE);
    assign O_err          = err_q;
    assign O_waddr        = waddr_q;
    assign O_wdata        = wdata_q;
    assign O_wr           = wr_q;
    assign O_maxi_arid    = '0;
    assign O_maxi_araddr  = addr_q;
    assign O_maxi_arlen   = arlen_q;
    assign O_maxi_arsize  = arsize_of(C_M_AXI_DATA_WIDTH);
    assign O_maxi_arburst = AXI_BURST_INCR;
    assign O_maxi_arcache = 4'b0011;
    assign O_maxi_arprot  = 3'b000;
    assign O_maxi_arvalid = (state_q == ST_ADDR);
    assign O_maxi_rready  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi_rd2ram_mburst.sv
// Table-driven bench for axi_rd2ram_mburst with a reactive AXI read slave and a
// RAM-write scoreboard; plus hand-written power-on and mid-job reset sequences.
module tb_axi_rd2ram_mburst;

    localparam int AW  = 32;
    localparam int DW  = 128;
    localparam int RW  = 10;
    localparam int LW  = 16;
    localparam int ALW = 8;
    localparam int IDW = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [AW-1:0]  base_addr = '0;
    logic [LW-1:0]  len = '0;
    logic [RW-1:0]  ram_base = '0;
    logic           ap_done, ap_idle, ap_ready, err, wr;
    logic [RW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic [IDW-1:0] arid;
    logic [AW-1:0]  araddr;
    logic [ALW-1:0] arlen;
    logic [2:0]     arsize, arprot;
    logic [1:0]     arburst;
    logic [3:0]     arcache;
    logic           arvalid, rready;
    logic           arready = 1'b0;
    logic [DW-1:0]  rdata = '0;
    logic [1:0]     rresp = 2'b00;
    logic           rlast = 1'b0;
    logic           rvalid = 1'b0;

    always #5 clk = ~clk;

    axi_rd2ram_mburst #(
        .C_M_AXI_ID_WIDTH(IDW), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
        .C_M_AXI_LEN_WIDTH(ALW), .C_RAM_ADDR_WIDTH(RW), .C_LEN_WIDTH(LW),
        .C_MAX_BURST(16), .C_MAX_OUTSTANDING(4)
    ) dut (
        .I_clk(clk), .I_rst(rst), .I_ap_start(start),
        .O_ap_done(ap_done), .O_ap_idle(ap_idle), .O_ap_ready(ap_ready),
        .I_base_addr(base_addr), .I_len(len), .I_ram_base(ram_base),
        .O_err(err), .O_waddr(waddr), .O_wdata(wdata), .O_wr(wr),
        .O_maxi_arid(arid), .O_maxi_araddr(araddr), .O_maxi_arlen(arlen),
        .O_maxi_arsize(arsize), .O_maxi_arburst(arburst), .O_maxi_arcache(arcache),
        .O_maxi_arprot(arprot), .O_maxi_arvalid(arvalid), .I_maxi_arready(arready),
        .I_maxi_rdata(rdata), .I_maxi_rresp(rresp), .I_maxi_rlast(rlast),
        .I_maxi_rvalid(rvalid), .O_maxi_rready(rready)
    );

    typedef struct {
        logic [31:0]       base;
        int                len;
        int                ram_base;
        int                err_beat;
        int                rdelay;
        int                exp_ars;
        logic [2:0][31:0]  ea;
        logic [2:0][7:0]   el;
        logic              exp_err;
        int                exp_first_r_ars;
        int                max_lat;
    } vec_t;

    vec_t vecs[8];

    int n_checks = 0;
    int n_pass   = 0;

    // job context shared by the slave model and the scoreboard
    logic [31:0] cur_base = '0;
    int cur_len = 0, cur_rb = 0, cur_err_beat = -1, cur_rdelay = 0;
    int cyc = 0, start_cyc = 0;
    int wr_cnt = 0, done_cnt = 0, done_cyc = 0;
    int out_cnt = 0, max_out = 0, ars_at_first_r = -1;
    bit first_r_seen = 0;
    logic [31:0] ar_addr_log[$];
    int          ar_len_log[$];
    logic [31:0] q_addr[$];
    int          q_len[$];
    int cur_beat = 0, glob_beat = 0;

    task automatic chk(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [127:0] dfun(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a, a + 32'h0000_1234, a};
    endfunction

    function automatic vec_t mk(input logic [31:0] base, input int l, input int rb,
                                input int eb, input int dly, input int ars,
                                input logic [31:0] a0, input int l0,
                                input logic [31:0] a1, input int l1,
                                input logic [31:0] a2, input int l2,
                                input logic e, input int fr, input int lat);
        vec_t v;
        v.base = base; v.len = l; v.ram_base = rb; v.err_beat = eb; v.rdelay = dly;
        v.exp_ars = ars;
        v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2;
        v.el[0] = 8'(l0); v.el[1] = 8'(l1); v.el[2] = 8'(l2);
        v.exp_err = e; v.exp_first_r_ars = fr; v.max_lat = lat;
        return v;
    endfunction

    // AXI read slave + monitor: decide handshakes on the falling edge, drive after the rising edge
    initial begin : slave
        bit ar_fire, r_fire, rst_s, hold_prev, exp_err_now;
        logic [31:0] ar_a, hold_addr, wr_end;
        int ar_l;
        logic [7:0] hold_len;
        hold_prev = 0; hold_addr = '0; hold_len = '0;
        forever begin
            @(negedge clk);
            cyc++;
            rst_s   = rst;
            ar_fire = arvalid && arready && !rst;
            r_fire  = rvalid && rready && !rst;
            ar_a    = araddr;
            ar_l    = int'(arlen);
            if (!rst) begin
                if (hold_prev)
                    chk(arvalid && araddr == hold_addr && arlen == hold_len, "ar_hold",
                        {arvalid, araddr, arlen}, {1'b1, hold_addr, hold_len});
                hold_prev = arvalid && !arready;
                hold_addr = araddr;
                hold_len  = arlen;
                if (ar_fire) begin
                    ar_addr_log.push_back(araddr);
                    ar_len_log.push_back(int'(arlen));
                    wr_end = {20'd0, araddr[11:0]} + (32'(arlen) + 32'd1) * 32'd16;
                    chk(wr_end <= 32'd4096, "ar_4kb_end", wr_end, 4096);
                end
                if (rvalid && !first_r_seen) begin
                    first_r_seen   = 1;
                    ars_at_first_r = ar_addr_log.size();
                end
                if (ar_fire) out_cnt++;
                if (r_fire && rlast) out_cnt--;
                if (out_cnt > max_out) max_out = out_cnt;
                if (wr) begin
                    exp_err_now = (cur_err_beat >= 0) && (wr_cnt >= cur_err_beat);
                    chk(waddr == RW'(cur_rb + wr_cnt), "wr_addr", waddr, RW'(cur_rb + wr_cnt));
                    chk(wdata == dfun(cur_base + 32'(wr_cnt) * 32'd16), "wr_data", wdata,
                        dfun(cur_base + 32'(wr_cnt) * 32'd16));
                    chk(err == exp_err_now, "err_at_write", err, exp_err_now);
                    wr_cnt++;
                end
                if (ap_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk(ap_ready == 1'b1, "ready_with_done", ap_ready, 1);
                end
            end else begin
                hold_prev = 0;
            end
            @(posedge clk);
            #1;
            if (rst_s) begin
                q_addr.delete(); q_len.delete();
                cur_beat = 0; glob_beat = 0;
                rvalid = 0; rlast = 0; rresp = 2'b00; arready = 0;
            end else begin
                if (ar_fire) begin
                    q_addr.push_back(ar_a);
                    q_len.push_back(ar_l);
                end
                if (r_fire) begin
                    glob_beat++;
                    if (cur_beat == q_len[0]) begin
                        void'(q_addr.pop_front());
                        void'(q_len.pop_front());
                        cur_beat = 0;
                    end else begin
                        cur_beat++;
                    end
                end
                arready = !arready;
                if (q_addr.size() > 0 && (cyc - start_cyc) >= cur_rdelay) begin
                    rvalid = 1;
                    rdata  = dfun(q_addr[0] + 32'(cur_beat) * 32'd16);
                    rlast  = (cur_beat == q_len[0]);
                    rresp  = (glob_beat == cur_err_beat) ? 2'b10 : 2'b00;
                end else begin
                    rvalid = 0; rlast = 0; rresp = 2'b00;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk(ap_idle == 1'b1, {tag, "_idle"}, ap_idle, 1);
        chk(ap_done == 1'b0, {tag, "_done"}, ap_done, 0);
        chk(ap_ready == 1'b0, {tag, "_ready"}, ap_ready, 0);
        chk(err == 1'b0, {tag, "_err"}, err, 0);
        chk(wr == 1'b0, {tag, "_wr"}, wr, 0);
        chk(arvalid == 1'b0, {tag, "_arvalid"}, arvalid, 0);
        chk(rready == 1'b0, {tag, "_rready"}, rready, 0);
        chk(waddr == '0, {tag, "_waddr"}, waddr, 0);
        chk(araddr == '0, {tag, "_araddr"}, araddr, 0);
        chk(arlen == '0, {tag, "_arlen"}, arlen, 0);
    endtask

    task automatic start_job(input vec_t v);
        cur_base = v.base & ~32'hF;
        cur_len = v.len; cur_rb = v.ram_base; cur_err_beat = v.err_beat; cur_rdelay = v.rdelay;
        wr_cnt = 0; done_cnt = 0; out_cnt = 0; max_out = 0;
        first_r_seen = 0; ars_at_first_r = -1; glob_beat = 0;
        ar_addr_log.delete(); ar_len_log.delete();
        base_addr = v.base; len = LW'(v.len); ram_base = RW'(v.ram_base);
        start = 1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 0;
        chk(ap_idle == 1'b0, "idle_low_after_start", ap_idle, 0);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        start_job(v);
        if (v.len > 0) begin
            // rising edge while busy must be ignored
            @(posedge clk); #1; start = 1;
            @(posedge clk); #1; start = 0;
        end
        for (int c = 0; c < 3000 && done_cnt == 0; c++) @(posedge clk);
        if (done_cnt == 0) chk(1'b0, "done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk(done_cnt == 1, "done_pulses", done_cnt, 1);
        chk((done_cyc - start_cyc) <= v.max_lat, "done_latency", done_cyc - start_cyc, v.max_lat);
        chk(ap_idle == 1'b1, "idle_after_done", ap_idle, 1);
        chk(wr_cnt == v.len, "write_count", wr_cnt, v.len);
        chk(ar_addr_log.size() == v.exp_ars, "ar_count", ar_addr_log.size(), v.exp_ars);
        for (int j = 0; j < 3 && j < v.exp_ars && j < ar_addr_log.size(); j++) begin
            chk(ar_addr_log[j] == v.ea[j], "ar_addr", ar_addr_log[j], v.ea[j]);
            chk(ar_len_log[j] == int'(v.el[j]), "ar_len", ar_len_log[j], v.el[j]);
        end
        chk(err == v.exp_err, "err_final", err, v.exp_err);
        chk(max_out <= 4, "max_outstanding", max_out, 4);
        if (v.exp_first_r_ars >= 0)
            chk(ars_at_first_r == v.exp_first_r_ars, "ars_before_first_r", ars_at_first_r,
                v.exp_first_r_ars);
        $display("job %0d: base=0x%0h len=%0d ram_base=%0d ars=%0d writes=%0d err=%0b", i,
                 v.base, v.len, v.ram_base, ar_addr_log.size(), wr_cnt, err);
    endtask

    initial begin : main
        vecs[0] = mk(32'h1000, 40, 0,    -1, 0,   3, 32'h1000, 15, 32'h1100, 15, 32'h1200, 7, 1'b0, -1, 3000);
        vecs[1] = mk(32'h1F80, 20, 256,  -1, 0,   2, 32'h1F80, 7,  32'h2000, 11, 32'h0, 0,    1'b0, -1, 3000);
        vecs[2] = mk(32'h4000, 128, 512, -1, 200, 8, 32'h4000, 15, 32'h4100, 15, 32'h4200, 15, 1'b0, 4, 3000);
        vecs[3] = mk(32'h5000, 0, 5,     -1, 0,   0, 32'h0, 0,     32'h0, 0,     32'h0, 0,    1'b0, -1, 4);
        vecs[4] = mk(32'h6000, 16, 64,   5,  0,   1, 32'h6000, 15, 32'h0, 0,     32'h0, 0,    1'b1, -1, 3000);
        vecs[5] = mk(32'h7008, 8, 1020,  -1, 0,   1, 32'h7000, 7,  32'h0, 0,     32'h0, 0,    1'b0, -1, 3000);
        vecs[6] = mk(32'h8FF0, 3, 16,    -1, 0,   2, 32'h8FF0, 0,  32'h9000, 1,  32'h0, 0,    1'b0, -1, 3000);
        vecs[7] = mk(32'h3000, 64, 0,    -1, 0,   4, 32'h3000, 15, 32'h3100, 15, 32'h3200, 15, 1'b0, -1, 3000);

        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        chk(arsize == 3'd4, "arsize", arsize, 4);
        chk(arburst == 2'b01, "arburst", arburst, 1);
        chk(arcache == 4'b0011, "arcache", arcache, 3);
        chk(arprot == 3'b000, "arprot", arprot, 0);
        chk(arid == '0, "arid", arid, 0);
        rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(i);

        // abort a job part-way through with a synchronous reset
        start_job(vecs[7]);
        for (int c = 0; c < 500 && wr_cnt < 5; c++) @(posedge clk);
        #1;
        chk(wr_cnt >= 5, "abort_progress", wr_cnt, 5);
        $display("abort: reset asserted after %0d writes", wr_cnt);
        rst = 1;
        @(posedge clk); #1;
        check_reset_outputs("midjob");
        @(posedge clk); #1;
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("postrst");

        run_vec(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d passes of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
